// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encoding, bit-period table and
// receiver state encoding, used by both the receiver and the transmitter.
package uart_pkg;

    localparam int CNT_W = 18;

    typedef enum logic [2:0] {
        BAUD_300        = 3'd0,
        BAUD_1200       = 3'd1,
        BAUD_2400       = 3'd2,
        BAUD_4800       = 3'd3,
        BAUD_9600       = 3'd4,
        BAUD_19200      = 3'd5,
        BAUD_115200     = 3'd6,
        BAUD_115200_ALT = 3'd7
    } baud_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Bit period in 50 MHz clk cycles: 1e9 / baud / 20, integer division.
    function automatic logic [CNT_W-1:0] bit_period(input baud_e code);
        case (code)
            BAUD_300:   return 18'd166666;
            BAUD_1200:  return 18'd41666;
            BAUD_2400:  return 18'd20833;
            BAUD_4800:  return 18'd10416;
            BAUD_9600:  return 18'd5208;
            BAUD_19200: return 18'd2604;
            default:    return 18'd434;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Signal bundle around the byte receiver: serial line and rate select in,
// received byte and status pulses out.
interface uart_rx_byte_if;
    logic       uart_rx;
    logic [2:0] baud_set;
    logic [7:0] byte_out;
    logic       rx_done;
    logic       frame_err;

    modport master (
        output uart_rx, baud_set,
        input  byte_out, rx_done, frame_err
    );

    modport slave (
        input  uart_rx, baud_set,
        output byte_out, rx_done, frame_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic line,
    output logic fall
);

    logic       meta;
    logic       prev;
    logic [2:0] armed;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            line  <= 1'b1;
            prev  <= 1'b1;
            armed <= '0;
        end else begin
            meta  <= din;
            line  <= meta;
            prev  <= line;
            armed <= {armed[1:0], 1'b1};
        end
    end

    // Edges are ignored until prev holds a real line sample, so a line that
    // is already low when reset drops is not mistaken for a start bit.
    assign fall = armed[2] & prev & ~line;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with selectable baud rate, mid-bit sampling,
// framing-error detection and break handling.
module uart_rx_byte
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] byte_out,
    output logic       rx_done,
    output logic       frame_err
);

    logic             line;
    logic             fall;
    rx_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] half_m1;
    logic [2:0]       bit_idx, bit_idx_next;
    baud_e            baud_q;
    logic [7:0]       shift;
    logic             latch_baud;
    logic             shift_en;
    logic             done_set;
    logic             err_set;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (uart_rx),
        .line (line),
        .fall (fall)
    );

    // Rate is frozen at the start edge, so mid-frame baud_set changes are inert.
    assign period  = bit_period(baud_q);
    assign half_m1 = (period >> 1) - 18'd1;

    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 18'd1;
        bit_idx_next = bit_idx;
        latch_baud   = 1'b0;
        shift_en     = 1'b0;
        done_set     = 1'b0;
        err_set      = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (fall) begin
                    state_next = ST_START;
                    latch_baud = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == half_m1) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == period - 18'd1) begin
                    cnt_next     = '0;
                    shift_en     = 1'b1;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == period - 18'd1) begin
                    cnt_next = '0;
                    if (line) begin
                        done_set   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) stays here, yielding a single frame_err.
                cnt_next = '0;
                if (line) state_next = ST_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: the shift register is a handful of flops, not a memory array, so
    // it takes the reset like any other state and a fresh frame never sees
    // stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            baud_q    <= BAUD_115200;
            shift     <= '0;
            byte_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            rx_done   <= done_set;
            frame_err <= err_set;
            if (latch_baud) baud_q   <= baud_e'(baud_set);
            if (shift_en)   shift    <= {line, shift[7:1]};
            if (done_set)   byte_out <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized bench for uart_rx_byte: frames are built and decoded by a
// bit-level model of an 8N1 line, and the receiver's pulses are scored.
module tb_uart_rx_byte;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;

    uart_rx_byte_if u_if ();

    uart_rx_byte dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (u_if.uart_rx),
        .baud_set  (u_if.baud_set),
        .byte_out  (u_if.byte_out),
        .rx_done   (u_if.rx_done),
        .frame_err (u_if.frame_err)
    );

    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned t_start;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything the receiver reports, sampled mid-cycle.
    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    int          err_seen  = 0;
    int          both_seen = 0;

    always @(negedge clk) begin
        if (u_if.rx_done) begin
            got_q.push_back(u_if.byte_out);
            got_t.push_back(cyc);
        end
        if (u_if.frame_err) err_seen++;
        if (u_if.rx_done && u_if.frame_err) both_seen++;
    end

    // Reference model state.
    logic [7:0] exp_q[$];
    logic [7:0] exp_last = 8'h00;
    int         exp_err  = 0;
    int         got_rd   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_period(input int code);
        int rates[8] = '{300, 1200, 2400, 4800, 9600, 19200, 115200, 115200};
        return 1000000000 / rates[code] / 20;
    endfunction

    function automatic logic [9:0] frame_bits(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        u_if.uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] bits, input int nbits, input int p, input int last_hold);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) t_start = cyc;
            u_if.uart_rx = bits[i];
            repeat ((i == nbits - 1) ? last_hold : p) @(posedge clk);
            #1;
        end
    endtask

    // A frame is good exactly when its stop bit is high; good frames carry bits 8:1.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p, input int stop_hold);
        logic [9:0] bits;
        bits = frame_bits(d, stop);
        drive_bits(bits, 10, p, stop_hold);
        if (bits[9]) begin
            exp_q.push_back(bits[8:1]);
            exp_last = bits[8:1];
        end else begin
            exp_err++;
        end
    endtask

    task automatic compare(input string tag);
        int n_got;
        n_got = got_q.size() - got_rd;
        check({tag, "_count"}, n_got, exp_q.size());
        for (int i = 0; i < n_got && i < exp_q.size(); i++)
            check({tag, "_byte"}, got_q[got_rd + i], exp_q[i]);
        check({tag, "_ferr"}, err_seen, exp_err);
        check({tag, "_byte_out"}, u_if.byte_out, exp_last);
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_latency(input string tag, input int p, input int idx, input int unsigned t0);
        int exp_lat;
        int lat;
        exp_lat = 2 + p / 2 + 9 * p + 1;
        if (got_t.size() > idx) begin
            lat = int'(got_t[idx] - t0);
            $display("%s: rx_done %0d cycles after start edge (nominal %0d)", tag, lat, exp_lat);
            check(tag, (lat >= exp_lat - 1 && lat <= exp_lat + 1), 1'b1);
        end else begin
            check({tag, "_present"}, got_t.size(), idx + 1);
        end
    endtask

    initial begin
        int p_fast;
        int p_slow;
        int idx;
        int unsigned t0;

        p_fast = model_period(6);
        p_slow = model_period(4);

        rst           = 1'b1;
        u_if.uart_rx  = 1'b1;
        u_if.baud_set = 3'd6;
        repeat (5) @(posedge clk);
        #1;
        check("rst_byte_out", u_if.byte_out, 8'h00);
        check("rst_rx_done", u_if.rx_done, 1'b0);
        check("rst_frame_err", u_if.frame_err, 1'b0);
        check("rst_state", dut.state, ST_IDLE);
        rst = 1'b0;
        idle(20);

        // Single frame and its latency.
        idle($urandom_range(1, 16));
        idx = got_q.size();
        send_frame(8'h55, 1'b1, p_fast, p_fast / 2 + 10);
        t0 = t_start;
        idle(10);
        check_latency("lat_55", p_fast, idx, t0);
        compare("single_55");

        // Back-to-back frames with a full-length stop bit and no idle gap.
        idle($urandom_range(1, 16));
        send_frame(8'hA5, 1'b1, p_fast, p_fast);
        send_frame(8'h3C, 1'b1, p_fast, p_fast / 2 + 10);
        idle(10);
        compare("b2b");

        // Short low glitch on an idle line must be rejected.
        u_if.uart_rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(p_fast);
        compare("glitch");
        check("glitch_state", dut.state, ST_IDLE);
        send_frame(8'h0F, 1'b1, p_fast, p_fast / 2 + 10);
        idle(10);
        compare("after_glitch");

        // Low stop bit followed by a 20-bit-period break.
        idle($urandom_range(1, 16));
        send_frame(8'hFF, 1'b0, p_fast, 20 * p_fast);
        idle(p_fast);
        compare("break");
        send_frame(8'h81, 1'b1, p_fast, p_fast / 2 + 10);
        idle(10);
        compare("after_break");

        // Slow frame with the rate select changed mid-frame.
        u_if.baud_set = 3'd4;
        idle($urandom_range(1, 16));
        idx = got_q.size();
        fork
            send_frame(8'h00, 1'b1, p_slow, p_slow / 2 + 10);
            begin
                repeat ($urandom_range(p_slow, 8 * p_slow)) @(posedge clk);
                #1;
                u_if.baud_set = 3'd6;
            end
        join
        t0 = t_start;
        idle(10);
        check_latency("lat_00_slow", p_slow, idx, t0);
        compare("slow_00");
        send_frame(8'hC3, 1'b1, p_fast, p_fast / 2 + 10);
        idle(10);
        compare("fast_after_slow");

        // Reset during data bit 4, then a line held low across reset release.
        idle($urandom_range(1, 16));
        drive_bits(frame_bits(8'h99, 1'b1), 6, p_fast, $urandom_range(1, p_fast - 1));
        rst          = 1'b1;
        u_if.uart_rx = 1'b0;
        exp_last     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_byte_out", u_if.byte_out, 8'h00);
        check("midrst_rx_done", u_if.rx_done, 1'b0);
        check("midrst_frame_err", u_if.frame_err, 1'b0);
        check("midrst_state", dut.state, ST_IDLE);
        rst = 1'b0;
        repeat (2 * p_fast) @(posedge clk);
        #1;
        check("low_after_rst_state", dut.state, ST_IDLE);
        compare("mid_reset");
        idle(20);
        send_frame(8'h99, 1'b1, p_fast, p_fast / 2 + 10);
        idle(10);
        compare("after_reset");

        check("done_err_overlap", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
